// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: parity modes, receiver FSM
// encoding and the parity-check helper.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rx_state_e;

    // data_xor is the XOR of all data bits; odd mode expects an odd total.
    function automatic logic parity_error(input logic data_xor, input logic par_bit,
                                          input int mode);
        return (data_xor ^ par_bit) != (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous first-word-fall-through FIFO; full/empty are told apart by an
// extra pointer MSB. Shared by the RX path and the planned TX path.
module uart_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a write when the head is popped in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop
            // samples pre-edge values, independent of statement order.
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    // NOTE: the storage array has no reset; empty-masking of rdata below gives
    // the defined zero output, and skipping the reset keeps it RAM-mappable.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign count = CW'(wptr - rptr);
    assign rdata = empty ? '0 : mem[rptr[AW-1:0]];

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: synchronizer, bit-centre sampling FSM, frame
// error capture, receive FIFO and sticky overrun flag.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int N           = 8,
    parameter int M           = 1,
    parameter int PARITY_MODE = 0,
    parameter int OS          = 16,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              tick,
    input  logic                              rx,
    input  logic                              rd_en,
    input  logic                              clr_ovr,
    output logic [N-1:0]                      data_out,
    output logic                              perr_out,
    output logic                              ferr_out,
    output logic                              empty,
    output logic                              full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
    output logic                              overrun
);

    localparam int SW = $clog2(OS);
    localparam int NW = $clog2(N);
    localparam logic [SW-1:0] S_HALF = SW'(OS / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(OS - 1);
    localparam logic [NW-1:0] N_LAST = NW'(N - 1);
    localparam logic [NW-1:0] M_LAST = NW'(M - 1);

    rx_state_e     state_q, state_d;
    logic [SW-1:0] s_q, s_d;
    logic [NW-1:0] n_q, n_d;
    logic [N-1:0]  sh_q, sh_d;
    logic          perr_q, perr_d;
    logic          ferr_q, ferr_d;
    logic          sync1, rxs;
    logic          stop_ferr;
    logic          push;
    logic [N+1:0]  fifo_rdata;

    // Synchronizer flops reset to the idle line level so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= rx;
            rxs   <= sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            n_q     <= '0;
            sh_q    <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            sh_q    <= sh_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    // The pushed ferr must include the stop sample taken on this very tick.
    assign stop_ferr = ferr_q | ~rxs;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can
        // leave a signal unassigned and infer a latch.
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        sh_d    = sh_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        push    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!rxs) begin
                    state_d = ST_START;
                    s_d     = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (s_q == S_HALF) begin
                        if (!rxs) begin
                            state_d = ST_DATA;
                            s_d     = '0;
                            n_d     = '0;
                            perr_d  = 1'b0;
                            ferr_d  = 1'b0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (s_q == S_LAST) begin
                        s_d  = '0;
                        sh_d = {rxs, sh_q[N-1:1]};
                        if (n_q == N_LAST) begin
                            state_d = (PARITY_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
                            n_d     = '0;
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    if (s_q == S_LAST) begin
                        s_d     = '0;
                        perr_d  = parity_error(^sh_q, rxs, PARITY_MODE);
                        state_d = ST_STOP;
                        n_d     = '0;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (s_q == S_LAST) begin
                        s_d    = '0;
                        ferr_d = stop_ferr;
                        if (n_q == M_LAST) begin
                            push    = 1'b1;
                            state_d = stop_ferr ? ST_BREAK : ST_IDLE;
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            ST_BREAK: begin
                if (rxs) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A simultaneous set and clear leaves the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (push && full && !rd_en) begin
            overrun <= 1'b1;
        end else if (clr_ovr) begin
            overrun <= 1'b0;
        end
    end

    uart_fifo #(
        .WIDTH (N + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (rd_en),
        .wdata ({stop_ferr, perr_q, sh_q}),
        .rdata (fifo_rdata),
        .empty (empty),
        .full  (full),
        .count (count)
    );

    assign ferr_out = fifo_rdata[N+1];
    assign perr_out = fifo_rdata[N];
    assign data_out = fifo_rdata[N-1:0];

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: an 8N1 instance and an 8E1 instance share
// clock, tick and reset; each has its own serial line and expected-entry queue.
module tb_uart_rx_os;

    localparam int N     = 8;
    localparam int OS    = 16;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef struct packed {
        logic         ferr;
        logic         perr;
        logic [N-1:0] data;
    } entry_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          tick = 1'b0;
    logic          line = 1'b1;
    logic          sel_p = 1'b0;
    logic          rd_en_a = 1'b0;
    logic          rd_en_p = 1'b0;
    logic          clr_ovr = 1'b0;
    logic          rx_a, rx_p;

    logic [N-1:0]  data_a, data_p;
    logic          perr_a, perr_p, ferr_a, ferr_p;
    logic          empty_a, empty_p, full_a, full_p, ovr_a, ovr_p;
    logic [CW-1:0] count_a, count_p;

    entry_t q_a[$];
    entry_t q_p[$];
    int checks = 0;
    int errors = 0;

    assign rx_a = sel_p ? 1'b1 : line;
    assign rx_p = sel_p ? line : 1'b1;

    uart_rx_os #(.N(N), .M(1), .PARITY_MODE(0), .OS(OS), .FIFO_DEPTH(DEPTH)) dut_a (
        .clk(clk), .reset(reset), .tick(tick), .rx(rx_a), .rd_en(rd_en_a),
        .clr_ovr(clr_ovr), .data_out(data_a), .perr_out(perr_a), .ferr_out(ferr_a),
        .empty(empty_a), .full(full_a), .count(count_a), .overrun(ovr_a)
    );

    uart_rx_os #(.N(N), .M(1), .PARITY_MODE(1), .OS(OS), .FIFO_DEPTH(DEPTH)) dut_p (
        .clk(clk), .reset(reset), .tick(tick), .rx(rx_p), .rd_en(rd_en_p),
        .clr_ovr(clr_ovr), .data_out(data_p), .perr_out(perr_p), .ferr_out(ferr_p),
        .empty(empty_p), .full(full_p), .count(count_p), .overrun(ovr_p)
    );

    always #5 clk = ~clk;

    // One-clk tick every 4 clocks, changed on the falling edge.
    initial begin : tick_gen
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            tick = (cnt == 3);
            cnt  = (cnt + 1) % 4;
        end
    end

    task automatic wait_ticks(input int k);
        for (int i = 0; i < k; i++) begin
            do @(posedge clk); while (!tick);
        end
        @(negedge clk);
    endtask

    task automatic send_frame(input logic sel, input logic [N-1:0] data,
                              input logic has_par, input logic par_bit,
                              input logic stop_val);
        sel_p = sel;
        line  = 1'b0;
        wait_ticks(OS);
        for (int i = 0; i < N; i++) begin
            line = data[i];
            wait_ticks(OS);
        end
        if (has_par) begin
            line = par_bit;
            wait_ticks(OS);
        end
        line = stop_val;
        wait_ticks(OS);
    endtask

    task automatic drain(input logic sel);
        entry_t got, exp;
        logic   emp;
        int     left;
        for (int i = 0; i < DEPTH + 2; i++) begin
            emp = sel ? empty_p : empty_a;
            if (emp) break;
            got = sel ? {ferr_p, perr_p, data_p} : {ferr_a, perr_a, data_a};
            checks++;
            if ((sel ? q_p.size() : q_a.size()) == 0) begin
                errors++;
                $display("FAIL drain_extra: dut%0d got entry %h, expected none", sel, got);
            end else begin
                if (sel) exp = q_p.pop_front();
                else     exp = q_a.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL drain_entry: dut%0d got {ferr,perr,data}=%h, expected %h",
                             sel, got, exp);
                end
            end
            if (sel) rd_en_p = 1'b1;
            else     rd_en_a = 1'b1;
            @(negedge clk);
            rd_en_p = 1'b0;
            rd_en_a = 1'b0;
        end
        left = sel ? q_p.size() : q_a.size();
        checks++;
        if (left != 0) begin
            errors++;
            $display("FAIL drain_missing: dut%0d still owes %0d entries, expected 0", sel, left);
        end
        q_a.delete();
        q_p.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({empty_a, full_a, count_a, ovr_a} !== {1'b1, 1'b0, CW'(0), 1'b0}) begin
            errors++;
            $display("FAIL reset_flags_a: empty/full/count/ovr=%b/%b/%0d/%b, expected 1/0/0/0",
                     empty_a, full_a, count_a, ovr_a);
        end
        checks++;
        if ({ferr_a, perr_a, data_a} !== '0) begin
            errors++;
            $display("FAIL reset_data_a: got %h, expected 0", {ferr_a, perr_a, data_a});
        end
        checks++;
        if ({empty_p, full_p, count_p, ovr_p} !== {1'b1, 1'b0, CW'(0), 1'b0}) begin
            errors++;
            $display("FAIL reset_flags_p: empty/full/count/ovr=%b/%b/%0d/%b, expected 1/0/0/0",
                     empty_p, full_p, count_p, ovr_p);
        end
        checks++;
        if ({ferr_p, perr_p, data_p} !== '0) begin
            errors++;
            $display("FAIL reset_data_p: got %h, expected 0", {ferr_p, perr_p, data_p});
        end
    endtask

    task automatic test_back_to_back();
        send_frame(1'b0, 8'h15, 1'b0, 1'b0, 1'b1);
        q_a.push_back('{ferr: 1'b0, perr: 1'b0, data: 8'h15});
        send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
        q_a.push_back('{ferr: 1'b0, perr: 1'b0, data: 8'h11});
        checks++;
        if (count_a !== CW'(2)) begin
            errors++;
            $display("FAIL b2b_count: count=%0d, expected 2", count_a);
        end
        drain(1'b0);
        checks++;
        if (count_a !== CW'(0) || empty_a !== 1'b1) begin
            errors++;
            $display("FAIL b2b_drained: count=%0d empty=%b, expected 0/1", count_a, empty_a);
        end
    endtask

    task automatic test_parity();
        logic [N-1:0] d;
        d = 8'hA5;
        for (int p = 1; p >= 0; p--) begin
            send_frame(1'b1, d, 1'b1, 1'(p), 1'b1);
            q_p.push_back('{ferr: 1'b0, perr: (^d) ^ 1'(p), data: d});
        end
        checks++;
        if (count_p !== CW'(2)) begin
            errors++;
            $display("FAIL parity_count: count=%0d, expected 2", count_p);
        end
        drain(1'b1);
    endtask

    task automatic test_framing();
        send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
        q_a.push_back('{ferr: 1'b1, perr: 1'b0, data: 8'h55});
        wait_ticks(3 * OS);
        line = 1'b1;
        wait_ticks(2 * OS);
        checks++;
        if (count_a !== CW'(1)) begin
            errors++;
            $display("FAIL break_count: count=%0d, expected 1", count_a);
        end
        drain(1'b0);
    endtask

    task automatic test_overrun();
        for (int i = 1; i <= 5; i++) begin
            send_frame(1'b0, 8'(i), 1'b0, 1'b0, 1'b1);
            if (i <= DEPTH) q_a.push_back('{ferr: 1'b0, perr: 1'b0, data: 8'(i)});
        end
        checks++;
        if ({full_a, count_a, ovr_a} !== {1'b1, CW'(DEPTH), 1'b1}) begin
            errors++;
            $display("FAIL ovr_full: full/count/ovr=%b/%0d/%b, expected 1/%0d/1",
                     full_a, count_a, ovr_a, DEPTH);
        end
        clr_ovr = 1'b1;
        @(negedge clk);
        clr_ovr = 1'b0;
        checks++;
        if (ovr_a !== 1'b0 || full_a !== 1'b1) begin
            errors++;
            $display("FAIL ovr_clear: ovr=%b full=%b, expected 0/1", ovr_a, full_a);
        end
        drain(1'b0);
    endtask

    task automatic test_glitch();
        sel_p = 1'b0;
        line  = 1'b0;
        wait_ticks(4);
        line = 1'b1;
        wait_ticks(2 * OS);
        checks++;
        if (empty_a !== 1'b1) begin
            errors++;
            $display("FAIL glitch_push: empty=%b, expected 1", empty_a);
        end
        send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
        q_a.push_back('{ferr: 1'b0, perr: 1'b0, data: 8'h5A});
        drain(1'b0);
    endtask

    task automatic test_reset_mid_frame();
        logic [N-1:0] d;
        d = 8'h3C;
        send_frame(1'b0, 8'h77, 1'b0, 1'b0, 1'b1);
        checks++;
        if (count_a !== CW'(1)) begin
            errors++;
            $display("FAIL rstmid_prefill: count=%0d, expected 1", count_a);
        end
        line = 1'b0;
        wait_ticks(OS);
        for (int i = 0; i < 3; i++) begin
            line = d[i];
            wait_ticks(OS);
        end
        line = d[3];
        wait_ticks(OS / 2);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        line  = 1'b1;
        wait_ticks(3 * OS);
        checks++;
        if ({empty_a, count_a, ovr_a} !== {1'b1, CW'(0), 1'b0}) begin
            errors++;
            $display("FAIL rstmid_flush: empty/count/ovr=%b/%0d/%b, expected 1/0/0",
                     empty_a, count_a, ovr_a);
        end
        q_a.delete();
        send_frame(1'b0, d, 1'b0, 1'b0, 1'b1);
        q_a.push_back('{ferr: 1'b0, perr: 1'b0, data: d});
        drain(1'b0);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_parity();
        test_framing();
        test_overrun();
        test_glitch();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Oversampling UART receiver with configurable frame format, per-frame error flags and a receive FIFO. It supersedes the plain receiver on the serial input path. It samples the line using the shared `baudrate_generator` tick at OS× the bit rate, and delivers bytes to the core through a first-word-fall-through pop interface. Parity, stop-bit count and data width are elaboration-time parameters.

## Interface
- `N`, 8, data bits per frame (5..9)
- `M`, 1, stop bits (1 or 2)
- `PARITY_MODE`, 0, parity mode: 0 none, 1 even, 2 odd
- `OS`, 16, ticks per bit period (even, ≥8)
- `FIFO_DEPTH`, 4, receive FIFO entries (power of 2, ≥2)

- `clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high; clears all state
- `tick`  in  1  one-`clk` pulse at BAUD_RATE×OS, from `baudrate_generator`
- `rx`  in  1  asynchronous serial line, idle high
- `rd_en`  in  1  pop head entry; ignored when `empty`
- `clr_ovr`  in  1  clears `overrun`
- `data_out`  out  N  head entry data, LSB = first received bit
- `perr_out`  out  1  head entry parity error
- `ferr_out`  out  1  head entry framing error
- `empty`  out  1  FIFO empty
- `full`  out  1  FIFO full
- `count`  out  $clog2(FIFO_DEPTH+1)  fill level
- `overrun`  out  1  sticky: a frame was dropped because the FIFO was full

## Operation
- `rx` passes through a 2-FF synchronizer whose flops reset to 1. The FSM uses only the synchronized value, `rxs`.
- `s` is the tick counter, $clog2(OS) bits. `n` is the bit counter. Both advance only on `tick`.
- IDLE: when `rxs`==0, go to START with s←0.
- START: on the tick with s==OS/2−1:
  - if `rxs`==0, go to DATA with s←0, n←0;
  - else treat as a glitch and return to IDLE.
  - Otherwise s++ on each tick.
- DATA: on the tick with s==OS−1, shift `rxs` into the MSB of the shift register (LSB-first order) and set s←0.
  - When n==N−1, go to PARITY (PARITY_MODE≠0) or STOP; else n++.
- PARITY: on the tick with s==OS−1, perr←(XOR(data)^rxs)≠(PARITY_MODE==2). Then go to STOP with n←0.
- STOP: on each tick with s==OS−1, sample `rxs`; any 0 sets ferr.
  - After the M-th stop sample, issue a push of {ferr, perr, data}.
  - Go to IDLE if ferr==0, else go to BREAK.
- BREAK: stay until `rxs`==1, then go to IDLE. This prevents a held-low line from retriggering frames.
- Push handling:
  - If !full, or full with `rd_en` in the same cycle, the entry is written.
  - Otherwise the frame is dropped and `overrun`←1.
- Pop: `rd_en` && !empty advances the read pointer. Push and pop in the same cycle leave `count` unchanged.
- `overrun` clears only on `reset` or `clr_ovr`. If a set and a clear occur in the same cycle, set wins.
- perr is forced to 0 when PARITY_MODE==0.

## Timing
- Reset values:
  - FSM IDLE; s, n, shift register = 0; synchronizer = 1;
  - FIFO pointers = 0, `empty`=1, `full`=0, `count`=0;
  - `overrun`=0; `data_out`, `perr_out`, `ferr_out` = 0.
- Reset mid-frame abandons the frame and flushes the FIFO. No push occurs.
- Line-to-FSM latency is 2 `clk` cycles (synchronizer).
- Each sample is taken at the bit centre: (OS/2 + k·OS) ticks after the start edge is detected.
- Push happens on the `clk` edge after the tick that samples the last stop bit. `empty` falls and `count` increments in that same cycle.
- `data_out`, `perr_out` and `ferr_out` are valid whenever !empty (first-word fall-through from registered storage). They update the cycle after a pop.
- Ticks arriving outside START/DATA/PARITY/STOP have no effect.
- Pointers wrap modulo FIFO_DEPTH. Full/empty are distinguished by an extra pointer MSB.

## Structure
- Package `uart_pkg`:
  - parity-mode constants `PAR_NONE`, `PAR_EVEN`, `PAR_ODD`;
  - FSM state encoding `ST_IDLE`, `ST_START`, `ST_DATA`, `ST_PARITY`, `ST_STOP`, `ST_BREAK`.
- Sub-module `uart_fifo`: synchronous FIFO with WIDTH=N+2 and DEPTH=FIFO_DEPTH.
  - Ports: push, pop, wdata, rdata, empty, full, count, plus `clk`/`reset`.
  - Reused by the future TX path.
- The receiver FSM, synchronizer and overrun flag live in `uart_rx_os`.

## Test plan
- 8N1, OS=16, send 0x15 then 0x11 → two entries in order: 0x15/perr0/ferr0, then 0x11/perr0/ferr0; `count` reaches 2, then pops to 0.
- PARITY_MODE=1, 0xA5 sent with parity bit 1 → `perr_out`=1. The same byte with parity bit 0 → `perr_out`=0.
- Stop bit driven low, then line held low for 3 bit periods → one entry with `ferr_out`=1. No further frames until `rx` returns high.
- FIFO_DEPTH=4, send 5 frames 0x01..0x05 with no reads → `full`=1, `overrun`=1, FIFO holds 0x01..0x04. `clr_ovr` clears `overrun`.
- Low pulse of 4 ticks on an idle line → no push, FSM back in IDLE.
- `reset` asserted during data bit 3 → nothing pushed, `empty`=1. The next clean frame 0x3C is received correctly.
